// File: rtl/btn_cmd_arbiter.sv
// Round-robin arbiter that latches button presses and hands them one at a time to a valid/ack command port.
// Define BTN_ARB_FIXED_PRI_EN to build fixed lowest-index-wins priority instead of round-robin.
module btn_cmd_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           cmd_ack,
  output logic           cmd_valid,
  output logic [IDW-1:0] cmd_id,
  output logic [N-1:0]   pending,
  output logic           timeout,
  output logic [7:0]     ovf_cnt
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [15:0] TIMER_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   grant, lost;
  logic [IDW-1:0] id_q, id_d, winner;
  logic           found;
  logic [15:0]    timer_q, timer_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     ovf_q, ovf_d;
  logic [8:0]     ovf_sum;
`ifndef BTN_ARB_FIXED_PRI_EN
  logic [IDW-1:0] last_q, last_d;
`endif

  // Winner search; round-robin looks above the last served index first, then wraps to the lowest set bit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef BTN_ARB_FIXED_PRI_EN
    for (int k = 0; k < N; k++) begin
      if (!found && pending_q[k]) begin
        found  = 1'b1;
        winner = IDW'(k);
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      if (!found && pending_q[k] && (IDW'(k) > last_q)) begin
        found  = 1'b1;
        winner = IDW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && pending_q[k]) begin
        found  = 1'b1;
        winner = IDW'(k);
      end
    end
`endif
  end

  always_comb begin
    grant = '0;
    if (state_q == IDLE && found) begin
      grant = {{(N-1){1'b0}}, 1'b1} << winner;
    end
    // A press on the bit being granted this cycle is a fresh request, not a lost one.
    pending_d = (pending_q & ~grant) | req;
    lost      = req & pending_q & ~grant;
    ovf_sum   = {1'b0, ovf_q} + 9'($countones(lost));
    ovf_d     = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
`ifndef BTN_ARB_FIXED_PRI_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = winner;
          timer_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cmd_ack) begin
`ifndef BTN_ARB_FIXED_PRI_EN
          last_d  = id_q;
`endif
          state_d = IDLE;
        end else if (TIMEOUT_EN && timer_q == TIMER_LAST) begin
          // The unacknowledged command is dropped, not re-queued.
          timeout_d = 1'b1;
`ifndef BTN_ARB_FIXED_PRI_EN
          last_d    = id_q;
`endif
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      id_q      <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      ovf_q     <= '0;
`ifndef BTN_ARB_FIXED_PRI_EN
      last_q    <= IDW'(N - 1);
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      id_q      <= id_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
`ifndef BTN_ARB_FIXED_PRI_EN
      last_q    <= last_d;
`endif
    end
  end

  assign cmd_valid = (state_q == BUSY);
  assign cmd_id    = id_q;
  assign pending   = pending_q;
  assign timeout   = timeout_q;
  assign ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed testbench for btn_cmd_arbiter (N=4, TIMEOUT=8, default round-robin build).
module tb_btn_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       cmdAck;
  logic       cmdValid;
  logic [1:0] cmdId;
  logic [3:0] pending;
  logic       timeoutPulse;
  logic [7:0] ovfCnt;
  logic [3:0] expPend;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  btn_cmd_arbiter #(.N(4), .IDW(2), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .cmd_ack  (cmdAck),
    .cmd_valid(cmdValid),
    .cmd_id   (cmdId),
    .pending  (pending),
    .timeout  (timeoutPulse),
    .ovf_cnt  (ovfCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives inputs for the current cycle, then moves to 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic a);
    req    = r;
    cmdAck = a;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(cmdValid), 32'd0);
    checkOutput("rst_id", 32'(cmdId), 32'd0);
    checkOutput("rst_timeout", 32'(timeoutPulse), 32'd0);
    checkOutput("rst_ovf", 32'(ovfCnt), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    req    = 4'hF;
    cmdAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_valid", 32'(cmdValid), 32'd0);
    checkOutput("init_id", 32'(cmdId), 32'd0);
    checkOutput("init_pending", 32'(pending), 32'd0);
    checkOutput("init_timeout", 32'(timeoutPulse), 32'd0);
    checkOutput("init_ovf", 32'(ovfCnt), 32'd0);
    rst = 1'b1;
    applyStimulus(4'h0, 1'b0);
    checkOutput("post_rst_pending", 32'(pending), 32'd0);
    checkOutput("post_rst_valid", 32'(cmdValid), 32'd0);

    $display("[TB] single press");
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_pend", 32'(pending), 32'h4);
    checkOutput("single_valid_t1", 32'(cmdValid), 32'd0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("single_valid_t2", 32'(cmdValid), 32'd1);
    checkOutput("single_id", 32'(cmdId), 32'd2);
    checkOutput("single_pend_clr", 32'(pending), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'h0, 1'b0);
      checkOutput("single_hold_valid", 32'(cmdValid), 32'd1);
      checkOutput("single_hold_id", 32'(cmdId), 32'd2);
    end
    applyStimulus(4'h0, 1'b1);
    checkOutput("single_done_valid", 32'(cmdValid), 32'd0);
    checkOutput("single_done_pend", 32'(pending), 32'd0);
    checkOutput("single_done_to", 32'(timeoutPulse), 32'd0);

    $display("[TB] round-robin sweep");
    resetDut();
    applyStimulus(4'hF, 1'b0);
    checkOutput("rr_pend_all", 32'(pending), 32'hF);
    for (int i = 0; i < 4; i++) begin
      expPend = 4'hF << (i + 1);
      applyStimulus(4'h0, 1'b0);
      checkOutput("rr_valid", 32'(cmdValid), 32'd1);
      checkOutput("rr_id", 32'(cmdId), 32'(i));
      checkOutput("rr_pend", 32'(pending), 32'(expPend));
      applyStimulus(4'h0, 1'b1);
      checkOutput("rr_gap", 32'(cmdValid), 32'd0);
    end

    $display("[TB] round-robin fairness");
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("fair_id0", 32'(cmdId), 32'd0);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("fair_busy_valid", 32'(cmdValid), 32'd1);
    checkOutput("fair_busy_id", 32'(cmdId), 32'd0);
    checkOutput("fair_busy_pend", 32'(pending), 32'h9);
    checkOutput("fair_no_ovf", 32'(ovfCnt), 32'd0);
    applyStimulus(4'h0, 1'b1);
    checkOutput("fair_gap", 32'(cmdValid), 32'd0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("fair_id3_first", 32'(cmdId), 32'd3);
    checkOutput("fair_pend1", 32'(pending), 32'h1);
    applyStimulus(4'h0, 1'b1);
    applyStimulus(4'h0, 1'b0);
    checkOutput("fair_id0_second", 32'(cmdId), 32'd0);
    checkOutput("fair_pend0", 32'(pending), 32'h0);
    applyStimulus(4'h0, 1'b1);

    $display("[TB] overflow");
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("ovf_busy_id0", 32'(cmdId), 32'd0);
    checkOutput("ovf_pend", 32'(pending), 32'h2);
    checkOutput("ovf_first", 32'(ovfCnt), 32'd0);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("ovf_two", 32'(ovfCnt), 32'd2);
    applyStimulus(4'h0, 1'b1);
    applyStimulus(4'h0, 1'b0);
    checkOutput("ovf_grant1", 32'(cmdId), 32'd1);
    checkOutput("ovf_grant1_valid", 32'(cmdValid), 32'd1);
    applyStimulus(4'h0, 1'b1);
    applyStimulus(4'h0, 1'b0);
    checkOutput("ovf_single_grant", 32'(cmdValid), 32'd0);
    checkOutput("ovf_hold", 32'(ovfCnt), 32'd2);
    repeat (400) applyStimulus(4'b0010, 1'b0);
    checkOutput("ovf_saturate", 32'(ovfCnt), 32'd255);

    $display("[TB] timeout");
    resetDut();
    applyStimulus(4'b1000, 1'b0);
    checkOutput("to_pend", 32'(pending), 32'h8);
    applyStimulus(4'h0, 1'b0);
    checkOutput("to_id3", 32'(cmdId), 32'd3);
    checkOutput("to_valid_v1", 32'(cmdValid), 32'd1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("to_valid_v2", 32'(cmdValid), 32'd1);
    checkOutput("to_pend_comp", 32'(pending), 32'h1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'h0, 1'b0);
      checkOutput("to_valid_hold", 32'(cmdValid), 32'd1);
      checkOutput("to_no_pulse", 32'(timeoutPulse), 32'd0);
    end
    applyStimulus(4'h0, 1'b0);
    checkOutput("to_valid_drop", 32'(cmdValid), 32'd0);
    checkOutput("to_pulse", 32'(timeoutPulse), 32'd1);
    checkOutput("to_pend_after", 32'(pending), 32'h1);
    applyStimulus(4'h0, 1'b0);
    checkOutput("to_next_valid", 32'(cmdValid), 32'd1);
    checkOutput("to_next_id", 32'(cmdId), 32'd0);
    checkOutput("to_pulse_once", 32'(timeoutPulse), 32'd0);
    applyStimulus(4'h0, 1'b1);

    $display("[TB] simultaneous press and grant");
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("sim_id", 32'(cmdId), 32'd2);
    checkOutput("sim_pend_kept", 32'(pending), 32'h4);
    checkOutput("sim_no_ovf", 32'(ovfCnt), 32'd0);
    applyStimulus(4'h0, 1'b1);
    checkOutput("sim_gap", 32'(cmdValid), 32'd0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("sim_regrant_valid", 32'(cmdValid), 32'd1);
    checkOutput("sim_regrant_id", 32'(cmdId), 32'd2);
    checkOutput("sim_regrant_pend", 32'(pending), 32'h0);
    applyStimulus(4'h0, 1'b1);

    $display("[TB] idle ack and mid-command reset");
    applyStimulus(4'h0, 1'b1);
    checkOutput("idle_ack_valid", 32'(cmdValid), 32'd0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'h0, 1'b0);
    checkOutput("abort_busy_id", 32'(cmdId), 32'd2);
    resetDut();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'h0, 1'b1);
      checkOutput("abort_valid", 32'(cmdValid), 32'd0);
      checkOutput("abort_timeout", 32'(timeoutPulse), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
